// File: rtl/mlow_packet_framer_if.sv
// Stream bundle between the codec and the framer (pkt_*), and between the framer and the
// transport sink (frm_*), plus the framer's status counters.
`timescale 1ns/1ps
interface mlow_packet_framer_if;
  logic [7:0]  pkt_data_i;
  logic        pkt_valid_i;
  logic        pkt_start_i;
  logic        pkt_end_i;
  logic        pkt_ready_o;
  logic [3:0]  bitrate_sel_i;
  logic [7:0]  frm_data_o;
  logic        frm_valid_o;
  logic        frm_ready_i;
  logic        frm_sof_o;
  logic        frm_eof_o;
  logic [15:0] frames_sent_o;
  logic [7:0]  drop_count_o;
  logic        busy_o;

  modport slave (
    input  pkt_data_i, pkt_valid_i, pkt_start_i, pkt_end_i, bitrate_sel_i, frm_ready_i,
    output pkt_ready_o, frm_data_o, frm_valid_o, frm_sof_o, frm_eof_o,
           frames_sent_o, drop_count_o, busy_o
  );

  modport master (
    output pkt_data_i, pkt_valid_i, pkt_start_i, pkt_end_i, bitrate_sel_i, frm_ready_i,
    input  pkt_ready_o, frm_data_o, frm_valid_o, frm_sof_o, frm_eof_o,
           frames_sent_o, drop_count_o, busy_o
  );
endinterface

// File: rtl/mlow_packet_framer.sv
// Buffers one encoded packet from the codec, then emits SYNC/SEQ/INFO/LEN, the payload and
// an XOR checksum with valid/ready backpressure; malformed or oversize packets are dropped.
`timescale 1ns/1ps
module mlow_packet_framer #(
  parameter int unsigned MAX_PAYLOAD = 240,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input logic                 clk_i,
  input logic                 reset_i,
  mlow_packet_framer_if.slave bus
);
  localparam int unsigned AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0]  MAX_LEN = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {IDLE, COLLECT, DISCARD, SEND_HDR, SEND_PAY, SEND_CHK} state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d, idx_q, idx_d, seq_q, seq_d, chk_q, chk_d, drop_q, drop_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  rate_q, rate_d;
  logic [15:0] frames_q, frames_d;
  logic        valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic        ready_q, ready_d, busy_q, busy_d;

  logic [7:0]  mem [MAX_PAYLOAD];
  logic        wr_en;
  logic [AW-1:0] wr_addr;
  logic        acc, xfer, begin_pkt, go_send, drop_evt;
  logic [7:0]  info;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    acc       = bus.pkt_valid_i && ready_q;
    xfer      = valid_q && bus.frm_ready_i;
    info      = {rate_q, 4'h0};
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    chk_d     = chk_q;
    drop_d    = drop_q;
    data_d    = data_q;
    rate_d    = rate_q;
    frames_d  = frames_q;
    valid_d   = valid_q;
    sof_d     = sof_q;
    eof_d     = eof_q;
    wr_en     = 1'b0;
    wr_addr   = len_q[AW-1:0];
    begin_pkt = 1'b0;
    go_send   = 1'b0;
    drop_evt  = 1'b0;

    case (state_q)
      IDLE, DISCARD: begin
        if (acc) begin
          if (bus.pkt_start_i)       begin_pkt = 1'b1;
          else if (state_q == IDLE)  drop_evt  = 1'b1;
          else if (bus.pkt_end_i)    state_d   = IDLE;
        end
      end
      COLLECT: begin
        if (acc) begin
          if (bus.pkt_start_i) begin
            drop_evt  = 1'b1;
            begin_pkt = 1'b1;
          end else if (len_q == MAX_LEN) begin
            drop_evt = 1'b1;
            state_d  = bus.pkt_end_i ? IDLE : DISCARD;
          end else begin
            wr_en   = 1'b1;
            len_d   = len_q + 8'd1;
            chk_d   = chk_q ^ bus.pkt_data_i;
            go_send = bus.pkt_end_i;
          end
        end
      end
      // Header bytes are preloaded one transfer ahead so the output never bubbles.
      SEND_HDR: begin
        if (xfer) begin
          sof_d = 1'b0;
          case (idx_q)
            8'd1: begin
              data_d = seq_q;
              idx_d  = 8'd2;
            end
            8'd2: begin
              data_d = info;
              idx_d  = 8'd3;
            end
            default: begin
              data_d  = len_q;
              idx_d   = 8'd0;
              state_d = SEND_PAY;
            end
          endcase
        end
      end
      SEND_PAY: begin
        if (xfer) begin
          if (idx_q == len_q) begin
            data_d  = seq_q ^ info ^ len_q ^ chk_q;
            eof_d   = 1'b1;
            state_d = SEND_CHK;
          end else begin
            data_d = mem[idx_q[AW-1:0]];
            idx_d  = idx_q + 8'd1;
          end
        end
      end
      SEND_CHK: begin
        if (xfer) begin
          valid_d  = 1'b0;
          eof_d    = 1'b0;
          data_d   = 8'd0;
          seq_d    = seq_q + 8'd1;
          frames_d = frames_q + 16'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (begin_pkt) begin
      wr_en   = 1'b1;
      wr_addr = '0;
      len_d   = 8'd1;
      rate_d  = bus.bitrate_sel_i;
      chk_d   = bus.pkt_data_i;
      state_d = COLLECT;
      go_send = bus.pkt_end_i;
    end
    if (go_send) begin
      state_d = SEND_HDR;
      valid_d = 1'b1;
      data_d  = SYNC_BYTE;
      sof_d   = 1'b1;
      idx_d   = 8'd1;
    end
    if (drop_evt) drop_d = sat_inc(drop_q);

    ready_d = (state_d == IDLE) || (state_d == COLLECT) || (state_d == DISCARD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      len_q    <= 8'd0;
      idx_q    <= 8'd0;
      seq_q    <= 8'd0;
      chk_q    <= 8'd0;
      drop_q   <= 8'd0;
      data_q   <= 8'd0;
      rate_q   <= 4'd0;
      frames_q <= 16'd0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      chk_q    <= chk_d;
      drop_q   <= drop_d;
      data_q   <= data_d;
      rate_q   <= rate_d;
      frames_q <= frames_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // Payload store holds no control meaning, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= bus.pkt_data_i;
  end

  assign bus.pkt_ready_o   = ready_q;
  assign bus.frm_data_o    = data_q;
  assign bus.frm_valid_o   = valid_q;
  assign bus.frm_sof_o     = sof_q;
  assign bus.frm_eof_o     = eof_q;
  assign bus.frames_sent_o = frames_q;
  assign bus.drop_count_o  = drop_q;
  assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_mlow_packet_framer.sv
// Randomized bench for mlow_packet_framer: a packet-level reference model builds the expected
// frame byte stream, and a negedge monitor compares every transferred byte against it.
`timescale 1ns/1ps
module tb_mlow_packet_framer;
  localparam int MAXP = 240;

  logic clk = 1'b0;
  logic reset_i;
  mlow_packet_framer_if bus();

  mlow_packet_framer #(.MAX_PAYLOAD(MAXP), .SYNC_BYTE(8'hA5)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  exp_q[$];
  logic [7:0]  cur[$];
  logic [7:0]  m_seq, m_drop, last_chk;
  logic [15:0] m_frames;
  logic [3:0]  cur_rate;
  bit          collecting, discarding, in_frame, hold_valid;
  logic [10:0] held;
  int          rmode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur.delete();
    m_seq = 8'd0; m_frames = 16'd0; m_drop = 8'd0;
    collecting = 1'b0; discarding = 1'b0;
  endtask

  task automatic model_drop();
    if (m_drop != 8'd255) m_drop++;
  endtask

  task automatic emit();
    logic [7:0] info, c;
    info = {cur_rate, 4'h0};
    c = m_seq ^ info ^ 8'(cur.size());
    exp_q.push_back({2'b10, 8'hA5});
    exp_q.push_back({2'b00, m_seq});
    exp_q.push_back({2'b00, info});
    exp_q.push_back({2'b00, 8'(cur.size())});
    foreach (cur[i]) begin
      exp_q.push_back({2'b00, cur[i]});
      c ^= cur[i];
    end
    exp_q.push_back({2'b01, c});
    m_seq++;
    m_frames++;
    collecting = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] d, input bit s, input bit e, input logic [3:0] r);
    if (s) begin
      if (collecting) model_drop();
      cur.delete();
      cur.push_back(d);
      cur_rate = r;
      collecting = 1'b1;
      discarding = 1'b0;
      if (e) emit();
    end else if (collecting) begin
      if (cur.size() == MAXP) begin
        model_drop();
        collecting = 1'b0;
        discarding = !e;
      end else begin
        cur.push_back(d);
        if (e) emit();
      end
    end else if (discarding) begin
      if (e) discarding = 1'b0;
    end else begin
      model_drop();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte has been taken.
  task automatic send_byte(input logic [7:0] d, input bit s, input bit e, input logic [3:0] r);
    bit acc = 1'b0;
    bus.pkt_data_i = d; bus.pkt_start_i = s; bus.pkt_end_i = e;
    bus.bitrate_sel_i = r; bus.pkt_valid_i = 1'b1;
    for (int i = 0; i < 3000 && !acc; i++) begin
      @(negedge clk);
      if (bus.pkt_ready_o === 1'b1) begin
        acc = 1'b1;
        model_accept(d, s, e, r);
      end
      @(posedge clk);
      #1;
    end
    bus.pkt_valid_i = 1'b0;
    if (!acc) check("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic send_pkt(input int n, input logic [3:0] r, input bit with_end);
    for (int i = 0; i < n; i++)
      send_byte(8'($urandom), i == 0, with_end && (i == n - 1), r);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (bus.busy_o === 1'b0 && exp_q.size() == 0) done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!done) check("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},   32'(bus.frm_data_o),    32'(0));
    check({tag, "_valid"},  32'(bus.frm_valid_o),   32'(0));
    check({tag, "_sof"},    32'(bus.frm_sof_o),     32'(0));
    check({tag, "_eof"},    32'(bus.frm_eof_o),     32'(0));
    check({tag, "_frames"}, 32'(bus.frames_sent_o), 32'(0));
    check({tag, "_drop"},   32'(bus.drop_count_o),  32'(0));
    check({tag, "_busy"},   32'(bus.busy_o),        32'(0));
    check({tag, "_ready"},  32'(bus.pkt_ready_o),   32'(0));
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       bus.frm_ready_i = 1'b1;
      1:       bus.frm_ready_i = ~bus.frm_ready_i;
      default: bus.frm_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (reset_i !== 1'b0) begin
      in_frame = 1'b0;
      hold_valid = 1'b0;
    end else begin
      if (bus.frm_valid_o) check("pkt_ready_in_send", 32'(bus.pkt_ready_o), 32'(0));
      if (hold_valid)
        check("hold_stable", 32'({bus.frm_valid_o, bus.frm_sof_o, bus.frm_eof_o, bus.frm_data_o}),
              32'(held));
      if (in_frame) check("no_bubble", 32'(bus.frm_valid_o), 32'(1));
      if (bus.frm_valid_o && bus.frm_ready_i) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'({bus.frm_sof_o, bus.frm_eof_o, bus.frm_data_o}), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", 32'({bus.frm_sof_o, bus.frm_eof_o, bus.frm_data_o}), 32'(e));
        end
        if (bus.frm_sof_o) in_frame = 1'b1;
        if (bus.frm_eof_o) begin
          in_frame = 1'b0;
          last_chk = bus.frm_data_o;
        end
        hold_valid = 1'b0;
      end else if (bus.frm_valid_o) begin
        hold_valid = 1'b1;
        held = {1'b1, bus.frm_sof_o, bus.frm_eof_o, bus.frm_data_o};
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int it;
    int kind;
    bus.pkt_valid_i = 1'b0; bus.pkt_data_i = 8'd0; bus.pkt_start_i = 1'b0;
    bus.pkt_end_i = 1'b0; bus.bitrate_sel_i = 4'd0; bus.frm_ready_i = 1'b1;
    rmode = 0; last_chk = 8'd0;
    reset_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_i = 1'b0;
    check("ready_before_edge", 32'(bus.pkt_ready_o), 32'(0));
    @(posedge clk); #1;
    check("ready_after_reset", 32'(bus.pkt_ready_o), 32'(1));

    // basic frame with first-byte latency
    send_byte(8'h11, 1, 0, 4'd3);
    send_byte(8'h22, 0, 0, 4'd3);
    send_byte(8'h33, 0, 1, 4'd3);
    check("latency_sync", 32'({bus.frm_valid_o, bus.frm_sof_o, bus.frm_data_o}), 32'({2'b11, 8'hA5}));
    wait_idle();
    check("basic_chk", 32'(last_chk), 32'(8'h33));
    check("basic_frames", 32'(bus.frames_sent_o), 32'(1));

    // backpressure with ready toggling
    rmode = 1;
    send_byte(8'h11, 1, 0, 4'd3);
    send_byte(8'h22, 0, 0, 4'd3);
    send_byte(8'h33, 0, 1, 4'd3);
    wait_idle();
    check("bp_chk", 32'(last_chk), 32'(8'h32));
    check("bp_frames", 32'(bus.frames_sent_o), 32'(2));

    // single byte packet
    rmode = 0;
    send_byte(8'h7F, 1, 1, 4'd3);
    wait_idle();
    check("single_chk", 32'(last_chk), 32'(8'h02 ^ 8'h30 ^ 8'h01 ^ 8'h7F));

    // exactly MAX_PAYLOAD frames; one more byte overflows
    send_pkt(MAXP, 4'd5, 1);
    wait_idle();
    check("maxlen_frames", 32'(bus.frames_sent_o), 32'(4));
    rmode = 2;
    send_pkt(MAXP + 1, 4'd6, 1);
    wait_idle();
    check("ovf_drop", 32'(bus.drop_count_o), 32'(1));
    check("ovf_frames", 32'(bus.frames_sent_o), 32'(4));
    send_pkt(4, 4'd7, 1);
    wait_idle();
    check("after_ovf_frames", 32'(bus.frames_sent_o), 32'(5));
    send_pkt(MAXP + 2, 4'd2, 1);
    wait_idle();
    check("discard_drop", 32'(bus.drop_count_o), 32'(2));

    // malformed input
    send_byte(8'h5A, 0, 0, 4'd1);
    check("lone_byte_drop", 32'(bus.drop_count_o), 32'(3));
    send_byte(8'h11, 1, 0, 4'd1);
    send_byte(8'h22, 0, 0, 4'd1);
    send_pkt(2, 4'd8, 1);
    wait_idle();
    check("restart_drop", 32'(bus.drop_count_o), 32'(4));
    check("restart_frames", 32'(bus.frames_sent_o), 32'(6));

    // random traffic, enough frames to wrap SEQ
    it = 0;
    while (m_frames < 16'd300 && it < 1500) begin
      kind = int'($urandom_range(0, 19));
      rmode = int'($urandom_range(0, 2));
      if (kind == 0)      send_byte(8'($urandom), 0, 1'($urandom_range(0, 1)), 4'($urandom));
      else if (kind == 1) send_pkt(int'($urandom_range(1, 3)), 4'($urandom), 0);
      else                send_pkt(int'($urandom_range(1, 12)), 4'($urandom), 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      it++;
    end
    wait_idle();
    check("rand_frames", 32'(bus.frames_sent_o), 32'(m_frames));
    check("rand_drop", 32'(bus.drop_count_o), 32'(m_drop));

    // drop counter saturation
    rmode = 0;
    send_byte(8'h01, 1, 1, 4'd0);
    wait_idle();
    repeat (260) send_byte(8'($urandom), 0, 0, 4'd0);
    check("drop_sat", 32'(bus.drop_count_o), 32'(255));
    check("drop_sat_model", 32'(bus.drop_count_o), 32'(m_drop));

    // asynchronous reset in the middle of the payload
    send_pkt(20, 4'h9, 1);
    repeat (6) @(posedge clk);
    #2;
    check("busy_before_reset", 32'(bus.busy_o), 32'(1));
    reset_i = 1'b1;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(posedge clk); #1;
    send_pkt(3, 4'd1, 1);
    wait_idle();
    check("post_reset_frames", 32'(bus.frames_sent_o), 32'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
